// File: rtl/ram_cmd_arbiter.sv
// Round-robin arbiter that shares the RAM command port between two requesters and
// expands each one-word read/write into the two-word RAM command sequence.
module ram_cmd_arbiter #(
    parameter int   ADDR_SIZE        = 8,
    parameter logic RESET_LAST_GRANT = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_wr,
    input  logic [2*ADDR_SIZE-1:0] req_addr,
    input  logic [2*ADDR_SIZE-1:0] req_wdata,
    output logic                   rsp_valid,
    output logic                   rsp_id,
    output logic                   rsp_wr,
    output logic [ADDR_SIZE-1:0]   rsp_rdata,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [ADDR_SIZE+1:0]   ram_din,
    output logic                   ram_rx_valid,
    input  logic [ADDR_SIZE-1:0]   ram_dout,
    input  logic                   ram_tx_valid
);

    typedef enum logic [2:0] {
        IDLE,
        W_ADDR,
        W_DATA,
        R_ADDR,
        R_CMD,
        R_WAIT
    } state_t;

    state_t                 state, state_nx;
    logic                   last_grant;
    logic                   cap_id;
    logic [ADDR_SIZE-1:0]   cap_wdata;

    logic                   accept;
    logic                   grant_id;
    logic                   sel_wr;
    logic [ADDR_SIZE-1:0]   sel_addr;
    logic [ADDR_SIZE-1:0]   sel_wdata;

    logic [ADDR_SIZE+1:0]   ram_din_nx;
    logic                   ram_rx_valid_nx;
    logic                   rsp_valid_nx;
    logic                   rsp_id_nx;
    logic                   rsp_wr_nx;
    logic [ADDR_SIZE-1:0]   rsp_rdata_nx;
    logic                   rsp_err_nx;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE) begin
            unique case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = last_grant ? 2'b01 : 2'b10;
                default: req_ready = 2'b00;
            endcase
        end
    end

    assign accept    = |req_ready;
    assign grant_id  = req_ready[1];
    assign sel_wr    = grant_id ? req_wr[1] : req_wr[0];
    assign sel_addr  = grant_id ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE]  : req_addr[ADDR_SIZE-1:0];
    assign sel_wdata = grant_id ? req_wdata[2*ADDR_SIZE-1:ADDR_SIZE] : req_wdata[ADDR_SIZE-1:0];
    assign busy      = (state != IDLE);

    // The first command word comes straight from the granted requester's inputs.
    always_comb begin
        state_nx        = state;
        ram_din_nx      = ram_din;
        ram_rx_valid_nx = 1'b0;
        rsp_valid_nx    = 1'b0;
        rsp_id_nx       = rsp_id;
        rsp_wr_nx       = rsp_wr;
        rsp_rdata_nx    = rsp_rdata;
        rsp_err_nx      = rsp_err;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    ram_rx_valid_nx = 1'b1;
                    if (sel_wr) begin
                        state_nx   = W_ADDR;
                        ram_din_nx = {2'b00, sel_addr};
                    end else begin
                        state_nx   = R_ADDR;
                        ram_din_nx = {2'b10, sel_addr};
                    end
                end
            end
            W_ADDR: begin
                state_nx        = W_DATA;
                ram_rx_valid_nx = 1'b1;
                ram_din_nx      = {2'b01, cap_wdata};
            end
            W_DATA: begin
                state_nx     = IDLE;
                rsp_valid_nx = 1'b1;
                rsp_id_nx    = cap_id;
                rsp_wr_nx    = 1'b1;
                rsp_rdata_nx = '0;
                rsp_err_nx   = 1'b0;
            end
            R_ADDR: begin
                state_nx        = R_CMD;
                ram_rx_valid_nx = 1'b1;
                ram_din_nx      = {2'b11, {ADDR_SIZE{1'b0}}};
            end
            R_CMD: begin
                state_nx = R_WAIT;
            end
            R_WAIT: begin
                state_nx     = IDLE;
                rsp_valid_nx = 1'b1;
                rsp_id_nx    = cap_id;
                rsp_wr_nx    = 1'b0;
                rsp_rdata_nx = ram_dout;
                rsp_err_nx   = ~ram_tx_valid;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_wr       <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            last_grant   <= RESET_LAST_GRANT;
            cap_id       <= 1'b0;
            cap_wdata    <= '0;
        end else begin
            ram_din      <= ram_din_nx;
            ram_rx_valid <= ram_rx_valid_nx;
            rsp_valid    <= rsp_valid_nx;
            rsp_id       <= rsp_id_nx;
            rsp_wr       <= rsp_wr_nx;
            rsp_rdata    <= rsp_rdata_nx;
            rsp_err      <= rsp_err_nx;
            if (accept) begin
                last_grant <= grant_id;
                cap_id     <= grant_id;
                cap_wdata  <= sel_wdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Scoreboard bench for ram_cmd_arbiter with a behavioural model of the shared RAM
// that decodes the command words and drives read data / read-valid back.
module tb_ram_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_id;
    logic        rsp_wr;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [9:0]  ram_din;
    logic        ram_rx_valid;
    logic [7:0]  ram_dout;
    logic        ram_tx_valid;

    always #5 clk = ~clk;

    ram_cmd_arbiter #(.ADDR_SIZE(8), .RESET_LAST_GRANT(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_wr       (rsp_wr),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .ram_din      (ram_din),
        .ram_rx_valid (ram_rx_valid),
        .ram_dout     (ram_dout),
        .ram_tx_valid (ram_tx_valid)
    );

    // RAM model: contents start as addr ^ 8'h5A, so 0x00 reads 0x5A and 0xFF reads 0xA5.
    logic [7:0] mem [256];
    logic [7:0] model_addr = 8'h00;
    logic [7:0] model_dout = 8'h00;
    logic       model_txv = 1'b0;
    logic       force_txv_low;

    assign ram_dout     = model_dout;
    assign ram_tx_valid = model_txv & ~force_txv_low;

    always @(posedge clk) begin
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00: begin model_addr <= ram_din[7:0]; model_txv <= 1'b0; end
                2'b01: begin mem[model_addr] <= ram_din[7:0]; model_txv <= 1'b0; end
                2'b10: begin model_addr <= ram_din[7:0]; model_txv <= 1'b0; end
                default: begin model_dout <= mem[model_addr]; model_txv <= 1'b1; end
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       id;
        logic       wr;
        logic [7:0] rdata;
        logic       err;
        int         due;
    } rsp_exp_t;

    typedef struct {
        logic [9:0] word;
        int         due;
    } cmd_exp_t;

    rsp_exp_t rsp_q[$];
    cmd_exp_t cmd_q[$];
    int       grant_log[$];
    int       accept_cyc[$];
    rsp_exp_t mon_rsp;
    cmd_exp_t mon_cmd;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Monitor: every response pulse and every RAM command strobe must match the next expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check_output("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    mon_rsp = rsp_q.pop_front();
                    check_output("rsp_id",    {31'd0, rsp_id},  {31'd0, mon_rsp.id});
                    check_output("rsp_wr",    {31'd0, rsp_wr},  {31'd0, mon_rsp.wr});
                    check_output("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, mon_rsp.rdata});
                    check_output("rsp_err",   {31'd0, rsp_err}, {31'd0, mon_rsp.err});
                    check_output("rsp_cycle", cyc, mon_rsp.due);
                end
            end
            if (ram_rx_valid) begin
                if (cmd_q.size() == 0) begin
                    check_output("cmd_unexpected", {31'd0, ram_rx_valid}, 32'd0);
                end else begin
                    mon_cmd = cmd_q.pop_front();
                    check_output("ram_din",   {22'd0, ram_din}, {22'd0, mon_cmd.word});
                    check_output("cmd_cycle", cyc, mon_cmd.due);
                end
            end
        end
    end

    // Presents one request, waits for its accept, then queues the commands and response it implies.
    task automatic apply_stimulus(input int id, input logic wr, input logic [7:0] addr,
                                  input logic [7:0] wdata, input logic [7:0] exp_rdata,
                                  input logic exp_err, input bit hold);
        bit got = 1'b0;
        int n;
        rsp_exp_t r;
        req_wr[id]           = wr;
        req_addr[id*8 +: 8]  = addr;
        req_wdata[id*8 +: 8] = wdata;
        req_valid[id]        = 1'b1;
        for (n = 0; n < 40 && !got; n++) begin
            #1;
            if (req_ready[id]) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            check_output("accept_timeout", {31'd0, req_ready[id]}, 32'd1);
            req_valid[id] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        grant_log.push_back(id);
        accept_cyc.push_back(cyc);
        r.id  = id[0];
        r.wr  = wr;
        if (wr) begin
            cmd_q.push_back('{word: {2'b00, addr},  due: cyc});
            cmd_q.push_back('{word: {2'b01, wdata}, due: cyc + 1});
            r.rdata = 8'h00;
            r.err   = 1'b0;
            r.due   = cyc + 2;
        end else begin
            cmd_q.push_back('{word: {2'b10, addr},  due: cyc});
            cmd_q.push_back('{word: 10'h300,       due: cyc + 1});
            r.rdata = exp_rdata;
            r.err   = exp_err;
            r.due   = cyc + 3;
        end
        rsp_q.push_back(r);
        if (!hold) req_valid[id] = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (n < 60 && (rsp_q.size() != 0 || cmd_q.size() != 0 || busy)) begin
            @(negedge clk);
            n++;
        end
        check_output("drain", rsp_q.size() + cmd_q.size() + {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        rst_n         = 1'b0;
        req_valid     = 2'b00;
        req_wr        = 2'b00;
        req_addr      = '0;
        req_wdata     = '0;
        force_txv_low = 1'b0;
        repeat (2) @(negedge clk);

        check_output("reset_ram_din",   {22'd0, ram_din}, 32'd0);
        check_output("reset_rx_valid",  {31'd0, ram_rx_valid}, 32'd0);
        check_output("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_output("reset_rsp_id",    {31'd0, rsp_id}, 32'd0);
        check_output("reset_rsp_wr",    {31'd0, rsp_wr}, 32'd0);
        check_output("reset_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        check_output("reset_rsp_err",   {31'd0, rsp_err}, 32'd0);
        check_output("reset_busy",      {31'd0, busy}, 32'd0);
        check_output("reset_ready",     {30'd0, req_ready}, 32'd0);
        req_valid = 2'b11;
        #1 check_output("first_tie_to_r0", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b10;
        #1 check_output("single_r1_ready", {30'd0, req_ready}, 32'd2);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] write r0 0x12 <- 0xA5, then read r1 0x12");
        apply_stimulus(0, 1'b1, 8'h12, 8'hA5, 8'h00, 1'b0, 1'b0);
        wait_drain();
        apply_stimulus(1, 1'b0, 8'h12, 8'h00, 8'hA5, 1'b0, 1'b0);
        wait_drain();

        $display("[TB] both requesters writing continuously");
        grant_log.delete();
        accept_cyc.delete();
        fork
            begin
                apply_stimulus(0, 1'b1, 8'h01, 8'h11, 8'h00, 1'b0, 1'b1);
                apply_stimulus(0, 1'b1, 8'h01, 8'h13, 8'h00, 1'b0, 1'b0);
            end
            begin
                apply_stimulus(1, 1'b1, 8'h02, 8'h22, 8'h00, 1'b0, 1'b1);
                apply_stimulus(1, 1'b1, 8'h02, 8'h24, 8'h00, 1'b0, 1'b0);
            end
        join
        wait_drain();
        check_output("grant_count", grant_log.size(), 32'd4);
        if (grant_log.size() == 4) begin
            for (int k = 0; k < 4; k++) check_output("grant_order", grant_log[k], k % 2);
            for (int k = 0; k < 3; k++) check_output("write_spacing", accept_cyc[k+1] - accept_cyc[k], 32'd3);
        end

        $display("[TB] back-to-back reads 0x00, 0xFF from r0");
        accept_cyc.delete();
        apply_stimulus(0, 1'b0, 8'h00, 8'h00, 8'h5A, 1'b0, 1'b1);
        apply_stimulus(0, 1'b0, 8'hFF, 8'h00, 8'hA5, 1'b0, 1'b0);
        wait_drain();
        check_output("read_count", accept_cyc.size(), 32'd2);
        if (accept_cyc.size() == 2) check_output("read_spacing", accept_cyc[1] - accept_cyc[0], 32'd4);

        $display("[TB] reset during R_CMD");
        req_wr[1]        = 1'b0;
        req_addr[15:8]   = 8'h12;
        req_valid        = 2'b10;
        #1 check_output("rst_case_ready", {30'd0, req_ready}, 32'd2);
        @(posedge clk);
        #1;
        cmd_q.push_back('{word: {2'b10, 8'h12}, due: cyc});
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        check_output("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("midrst_busy",      {31'd0, busy}, 32'd0);
        check_output("midrst_rx_valid",  {31'd0, ram_rx_valid}, 32'd0);
        check_output("midrst_ram_din",   {22'd0, ram_din}, 32'd0);
        check_output("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_output("midrst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_output("midrst_no_rsp", rsp_q.size() + cmd_q.size(), 32'd0);
        apply_stimulus(1, 1'b0, 8'h12, 8'h00, 8'hA5, 1'b0, 1'b0);
        wait_drain();

        $display("[TB] read with RAM read-valid forced low");
        force_txv_low = 1'b1;
        apply_stimulus(0, 1'b0, 8'hFF, 8'h00, 8'hA5, 1'b1, 1'b0);
        wait_drain();
        force_txv_low = 1'b0;
        check_output("err_back_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_cmd_arbiter.md
Name: ram_cmd_arbiter

Overview:
- Shares the 10-bit command port of the synchronous single-port RAM between two requesters (0 = SPI slave side, 1 = local host/debug side).
- Each requester issues one-word read or write transactions with a valid/ready handshake.
- The block arbitrates round-robin and expands each transaction into the RAM command sequence:
  - Write: {00,addr} then {01,data}.
  - Read: {10,addr} then {11,x}.
- Read data returns on one shared response channel tagged with the requester ID.

Parameters:
- ADDR_SIZE, 8, RAM address and data width. Fixed at 8 because the RAM command word is {2-bit opcode, 8-bit payload}.
- RESET_LAST_GRANT, 1, initial value of the round-robin pointer. With 1, requester 0 wins the first tie.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept; one-hot or zero.
- req_wr  input  2  per-requester op: 1 = write, 0 = read.
- req_addr  input  2*ADDR_SIZE  per-requester address; requester i uses bits [i*8 +: 8].
- req_wdata  input  2*ADDR_SIZE  per-requester write data, same packing as req_addr.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_id  output  1  requester ID the response belongs to.
- rsp_wr  output  1  1 = write ack, 0 = read data.
- rsp_rdata  output  ADDR_SIZE  read data; 0 for write acks.
- rsp_err  output  1  read completed but ram_tx_valid was 0 in the capture cycle.
- busy  output  1  high whenever the FSM is not in IDLE.
- ram_din  output  10  command word to the RAM.
- ram_rx_valid  output  1  command strobe to the RAM.
- ram_dout  input  ADDR_SIZE  RAM read data.
- ram_tx_valid  input  1  RAM read-valid. The RAM holds it high after a {11} command until its next command.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
  - Reset values: state=IDLE, ram_rx_valid=0, ram_din=0, rsp_valid=0, rsp_id=0, rsp_wr=0, rsp_rdata=0, rsp_err=0, last_grant=RESET_LAST_GRANT, captured request registers=0.
- Outputs: every output except req_ready and busy is registered. req_ready is combinational from state, req_valid and last_grant. busy = (state != IDLE).
- Arbitration:
  - Happens only in IDLE.
  - If exactly one req_valid bit is set, that requester gets ready.
  - If both are set, ready goes to the requester != last_grant.
  - When no request is valid, req_ready = 00.
  - Outside IDLE, req_ready = 00.
- Handshake and capture: a request is accepted at edge T when req_valid[i] & req_ready[i]. At that edge:
  - wr, addr and wdata of requester i are captured.
  - last_grant <= i.
  - The FSM leaves IDLE.
- FSM states: IDLE, W_ADDR, W_DATA, R_ADDR, R_CMD, R_WAIT. "After edge" below means the registered values that become visible after that edge.
  - Write, after edge T: W_ADDR, ram_rx_valid=1, ram_din={00,addr}.
  - Write, after T+1: W_DATA, ram_din={01,wdata}.
  - Write, after T+2: IDLE, ram_rx_valid=0, rsp_valid=1, rsp_wr=1, rsp_rdata=0, rsp_err=0, rsp_id=i. The RAM commits the write at edge T+2.
  - Read, after T: R_ADDR, ram_rx_valid=1, ram_din={10,addr}.
  - Read, after T+1: R_CMD, ram_din={11,8'h00}.
  - Read, after T+2: R_WAIT, ram_rx_valid=0.
  - Read, at edge T+3: rsp_rdata <= ram_dout, rsp_err <= ~ram_tx_valid, rsp_valid=1, rsp_wr=0, rsp_id=i; state returns to IDLE.
- Latency:
  - Write: ack is visible 2 cycles after accept.
  - Read: data is visible 3 cycles after accept.
  - Next accept: possible in the cycle the response is visible.
  - Throughput: one write per 3 cycles, one read per 4 cycles.
- Response pulse: rsp_valid is high for exactly one cycle and has no back-pressure. rsp_rdata and rsp_err hold their value until the next response.
- ram_rx_valid: never high in IDLE or R_WAIT. ram_din holds its last value when ram_rx_valid=0.
- A requester dropping req_valid after acceptance has no effect; the transaction completes.
- Simultaneous events: a new request presented in the response cycle is accepted in that same cycle. The response pulse and the new accept may coincide.
- Reset mid-operation: all registers return to their reset values immediately, and the in-flight transaction is dropped with no response. The RAM contents and the RAM's internal address registers are not affected by this block.
- Address range: the full 8-bit range 0x00..0xFF is legal; there is no wrap or saturation logic.

Test Plan:
- Reset, then requester 0 writes addr 0x12 data 0xA5 -> RAM sees {00,0x12} then {01,0xA5} on consecutive cycles; rsp_valid=1, rsp_id=0, rsp_wr=1 two cycles after accept.
- Requester 1 reads addr 0x12 after that write -> commands {10,0x12}, {11,0x00}; rsp_rdata=0xA5, rsp_err=0, rsp_id=1, three cycles after accept.
- Both requesters assert valid continuously with writes (addr 0x01 / 0x02) -> grants alternate 0,1,0,1, and each write completes before the next accept.
- Back-to-back reads of 0x00 then 0xFF from requester 0 with req_valid held high -> second accept occurs in the first response cycle; data returns in order and ram_rx_valid is low during R_WAIT.
- rst_n asserted during R_CMD -> all outputs are 0 within the same cycle, busy=0, and no rsp_valid follows; a subsequent read of 0x12 still returns 0xA5.
- Forced ram_tx_valid=0 in R_WAIT (bench model) -> rsp_valid=1 with rsp_err=1, and the FSM returns to IDLE.
